nios_jtag_host_sequencer: RTL and testbench
===========================================

Name: nios_jtag_host_sequencer

Overview:
- Host-side driver for the Nios II CPU JTAG debug module's virtual-JTAG slave interface. It is the initiator end of the same protocol.
- Takes one debug transaction per command on the system clock: an IR value plus an optional data-register payload.
- Generates the virtual-JTAG signal set (tck, tdi, ir_in and the uir/cdr/sdr/udr/rti state strobes) that the debug module's tck/sysclk halves expect.
- Collects tdo and ir_out and returns them as a response. Used for on-chip debug access and for driving the debug module in simulation, where the real virtual-JTAG hub is absent.

Parameters:
- DR_W, 38, data-register length in bits (shift count per SDR phase).
- IR_W, 2, virtual IR width.
- TCK_DIV, 2, clk cycles per tck half-period; legal range 1..255.
- RTI_CYC, 1, number of tck periods spent in RTI after each transaction; legal range 1..15.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_ir  in  IR_W  IR value driven on vji_ir_in.
- cmd_dr  in  DR_W  data shifted out on tdi, LSB first.
- cmd_skip_dr  in  1  1 = IR-only transaction (no CDR/SDR/UDR).
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_dr  out  DR_W  captured tdo bits; bit i = tdo sampled in SDR period i.
- rsp_ir_out  out  IR_W  vji_ir_out sampled at the UIR rising edge.
- vji_tck  out  1  generated JTAG clock.
- vji_tdi  out  1  serial data to the target.
- vji_tdo  in  1  serial data from the target.
- vji_ir_in  out  IR_W  virtual IR to the target.
- vji_ir_out  in  IR_W  status from the target.
- vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti  out  1 each  virtual state strobes.

Behaviour:
- **Reset.** Reset is synchronous and active-low on clk. All outputs reset to 0: tck, tdi, ir_in, all strobes, rsp_valid, rsp_dr, rsp_ir_out. cmd_ready also resets to 0. FSM resets to IDLE. cmd_ready rises the cycle after reset_n deasserts.
- **Reset mid-transaction.** The transaction is abandoned. No response is produced. All vji outputs return to 0 the cycle after reset is sampled.
- **States.** IDLE -> UIR -> CDR -> SDR -> UDR -> RTI -> RESP -> IDLE.
  - With cmd_skip_dr=1 the path is IDLE -> UIR -> RTI -> RESP.
- **Command acceptance.**
  - cmd_ready = (state==IDLE). Because of the RESP state, no new command is accepted while a response is pending.
  - The handshake latches cmd_ir, cmd_dr and cmd_skip_dr.
  - vji_ir_in takes cmd_ir on the cycle after the handshake. It holds that value until the next accepted command; it does not return to 0 in IDLE.
- **tck timing.**
  - Each tck period is 2*TCK_DIV clk cycles: TCK_DIV cycles low, then TCK_DIV cycles high.
  - Period k of a transaction begins at cycle 1+2*TCK_DIV*k, where the handshake is cycle 0.
  - vji_tck is 0 in IDLE and RESP.
- **Strobe and tdi timing.**
  - Strobes and tdi change only at period start, i.e. on the tck falling edge.
  - Exactly one strobe is high per period. All strobes are 0 in IDLE and RESP.
- **Sampling.**
  - vji_tdo and vji_ir_out are sampled on the clk cycle in which vji_tck goes 0->1. This captures the value the target presents before it shifts.
- **UIR.** 1 period. rsp_ir_out is captured at its rising edge.
- **CDR.** 1 period. tdi = 0.
- **SDR.**
  - DR_W periods. In period i, tdi = cmd_dr[i].
  - rsp_dr[i] <= tdo sampled at period i's rising edge.
  - A shift counter runs 0..DR_W-1 with no wrap; the exit is at DR_W-1.
- **UDR.** 1 period. tdi = 0.
- **RTI.** RTI_CYC periods.
- **Skipped DR.** With cmd_skip_dr=1, rsp_dr holds its previous value.
- **RESP.**
  - rsp_valid rises at cycle 1+2*TCK_DIV*N, where N = 1 + (skip ? 0 : DR_W+2) + RTI_CYC.
  - rsp_valid, rsp_dr and rsp_ir_out are held stable until rsp_ready.
  - rsp_valid falls on the cycle after the handshake. The FSM returns to IDLE and cmd_ready rises on that same cycle.
  - rsp_ready=1 in the rsp_valid rise cycle completes immediately.
- **Other inputs.** cmd_valid outside IDLE is ignored. cmd_* may change freely after acceptance.

Test Plan:
- **Reset.** Hold reset_n=0 for 3 cycles -> all outputs 0. cmd_ready=1 on the first cycle after release.
- **Full transaction, loopback.** Defaults; cmd_ir=2'b01, cmd_dr=38'h2A_5A5A_A5A5; target model loops tdi to tdo with one-period delay.
  - rsp_valid at cycle 169.
  - rsp_dr = {cmd_dr[36:0],1'b0}.
  - Per period: exactly 1 uir, 1 cdr, 38 sdr, 1 udr, 1 rti period.
- **IR-only, ir_out capture.** cmd_skip_dr=1, cmd_ir=2'b10, vji_ir_out=2'b11.
  - rsp_valid at cycle 9.
  - rsp_ir_out=2'b11.
  - No cdr/sdr/udr pulses; rsp_dr unchanged.
- **TCK_DIV=1.** tck toggles every clk cycle. tdi is stable across each rising edge. rsp_valid at cycle 85.
- **Response backpressure.** Hold rsp_ready=0 for 20 cycles and drive cmd_valid=1 throughout.
  - cmd_ready stays 0 and rsp_dr is stable.
  - After rsp_ready=1, the next command is accepted exactly 1 cycle after the response handshake.
- **Mid-shift reset.** Assert reset_n=0 during SDR period 10.
  - Next cycle: all vji strobes, tck and tdi are 0; rsp_valid=0.
  - A following command completes normally with correct data.

Source files
------------

// File: rtl/nios_jtag_host_sequencer_if.sv
// Command/response handshake bundle between a debug host and nios_jtag_host_sequencer.
// The host drives the master side; the sequencer sits on the slave side.
interface nios_jtag_host_sequencer_if #(
  parameter int DR_W = 38,
  parameter int IR_W = 2
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [IR_W-1:0] cmd_ir;
  logic [DR_W-1:0] cmd_dr;
  logic            cmd_skip_dr;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [DR_W-1:0] rsp_dr;
  logic [IR_W-1:0] rsp_ir_out;

  modport master (
    output cmd_valid, cmd_ir, cmd_dr, cmd_skip_dr, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_dr, rsp_ir_out
  );

  modport slave (
    input  cmd_valid, cmd_ir, cmd_dr, cmd_skip_dr, rsp_ready,
    output cmd_ready, rsp_valid, rsp_dr, rsp_ir_out
  );
endinterface

// File: rtl/nios_jtag_host_sequencer.sv
// Initiator for the Nios II debug module's virtual-JTAG slave: turns one IR/DR command
// into a tck-paced UIR/CDR/SDR/UDR/RTI strobe sequence and returns the captured tdo/ir_out.
module nios_jtag_host_sequencer #(
  parameter int DR_W    = 38,
  parameter int IR_W    = 2,
  parameter int TCK_DIV = 2,
  parameter int RTI_CYC = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  nios_jtag_host_sequencer_if.slave host,
  output logic            vji_tck,
  output logic            vji_tdi,
  input  logic            vji_tdo,
  output logic [IR_W-1:0] vji_ir_in,
  input  logic [IR_W-1:0] vji_ir_out,
  output logic            vji_uir,
  output logic            vji_cdr,
  output logic            vji_sdr,
  output logic            vji_udr,
  output logic            vji_rti
);
  localparam int DIV_W   = 8;
  localparam int RTI_W   = 4;
  localparam int SHIFT_W = (DR_W > 1) ? $clog2(DR_W) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(TCK_DIV - 1);
  localparam logic [RTI_W-1:0]   RTI_LAST   = RTI_W'(RTI_CYC - 1);
  localparam logic [SHIFT_W-1:0] SHIFT_LAST = SHIFT_W'(DR_W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR, S_RTI, S_RESP
  } state_e;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [SHIFT_W-1:0]  shift_q, shift_d;
  logic [RTI_W-1:0]    rti_cnt_q, rti_cnt_d;
  logic                skip_q, skip_d;
  logic [DR_W-1:0]     dr_q, dr_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DR_W-1:0]     rsp_dr_q, rsp_dr_d;
  logic [IR_W-1:0]     rsp_ir_out_q, rsp_ir_out_d;
  logic                tck_q, tck_d;
  logic                tdi_q, tdi_d;
  logic [IR_W-1:0]     ir_in_q, ir_in_d;
  logic                uir_q, uir_d;
  logic                cdr_q, cdr_d;
  logic                sdr_q, sdr_d;
  logic                udr_q, udr_d;
  logic                rti_q, rti_d;

  logic in_tx, half_end, tck_rise, tck_fall, cmd_fire, rsp_fire;

  always_comb begin
    in_tx    = (state_q != S_IDLE) && (state_q != S_RESP);
    half_end = (div_q == DIV_LAST);
    tck_rise = in_tx && half_end && !tck_q;
    tck_fall = in_tx && half_end && tck_q;
    cmd_fire = (state_q == S_IDLE) && cmd_ready_q && host.cmd_valid;
    rsp_fire = (state_q == S_RESP) && host.rsp_ready;
  end

  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    shift_d      = shift_q;
    rti_cnt_d    = rti_cnt_q;
    skip_d       = skip_q;
    dr_d         = dr_q;
    cmd_ready_d  = cmd_ready_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_dr_d     = rsp_dr_q;
    rsp_ir_out_d = rsp_ir_out_q;
    tck_d        = tck_q;
    tdi_d        = tdi_q;
    ir_in_d      = ir_in_q;
    uir_d        = uir_q;
    cdr_d        = cdr_q;
    sdr_d        = sdr_q;
    udr_d        = udr_q;
    rti_d        = rti_q;

    if (in_tx) begin
      div_d = half_end ? '0 : div_q + 1'b1;
    end

    // Target inputs are captured on the edge that raises tck, before the target shifts.
    if (tck_rise) begin
      tck_d = 1'b1;
      if (state_q == S_UIR) rsp_ir_out_d = vji_ir_out;
      if (state_q == S_SDR) rsp_dr_d[shift_q] = vji_tdo;
    end

    // Every falling edge opens the next period: pick its strobe and tdi.
    if (tck_fall) begin
      tck_d = 1'b0;
      tdi_d = 1'b0;
      uir_d = 1'b0;
      cdr_d = 1'b0;
      sdr_d = 1'b0;
      udr_d = 1'b0;
      rti_d = 1'b0;
      case (state_q)
        S_UIR: begin
          if (skip_q) begin
            state_d   = S_RTI;
            rti_d     = 1'b1;
            rti_cnt_d = '0;
          end else begin
            state_d = S_CDR;
            cdr_d   = 1'b1;
          end
        end
        S_CDR: begin
          state_d = S_SDR;
          sdr_d   = 1'b1;
          shift_d = '0;
          tdi_d   = dr_q[0];
          dr_d    = dr_q >> 1;
        end
        S_SDR: begin
          if (shift_q == SHIFT_LAST) begin
            state_d = S_UDR;
            udr_d   = 1'b1;
          end else begin
            sdr_d   = 1'b1;
            shift_d = shift_q + 1'b1;
            tdi_d   = dr_q[0];
            dr_d    = dr_q >> 1;
          end
        end
        S_UDR: begin
          state_d   = S_RTI;
          rti_d     = 1'b1;
          rti_cnt_d = '0;
        end
        S_RTI: begin
          if (rti_cnt_q == RTI_LAST) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
          end else begin
            rti_d     = 1'b1;
            rti_cnt_d = rti_cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (cmd_fire) begin
      state_d     = S_UIR;
      cmd_ready_d = 1'b0;
      ir_in_d     = host.cmd_ir;
      dr_d        = host.cmd_dr;
      skip_d      = host.cmd_skip_dr;
      uir_d       = 1'b1;
      tck_d       = 1'b0;
      tdi_d       = 1'b0;
      div_d       = '0;
    end else if (state_q == S_IDLE) begin
      cmd_ready_d = 1'b1;
    end

    if (rsp_fire) begin
      state_d     = S_IDLE;
      rsp_valid_d = 1'b0;
      cmd_ready_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      div_q        <= '0;
      shift_q      <= '0;
      rti_cnt_q    <= '0;
      skip_q       <= 1'b0;
      dr_q         <= '0;
      cmd_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_dr_q     <= '0;
      rsp_ir_out_q <= '0;
      tck_q        <= 1'b0;
      tdi_q        <= 1'b0;
      ir_in_q      <= '0;
      uir_q        <= 1'b0;
      cdr_q        <= 1'b0;
      sdr_q        <= 1'b0;
      udr_q        <= 1'b0;
      rti_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      shift_q      <= shift_d;
      rti_cnt_q    <= rti_cnt_d;
      skip_q       <= skip_d;
      dr_q         <= dr_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_dr_q     <= rsp_dr_d;
      rsp_ir_out_q <= rsp_ir_out_d;
      tck_q        <= tck_d;
      tdi_q        <= tdi_d;
      ir_in_q      <= ir_in_d;
      uir_q        <= uir_d;
      cdr_q        <= cdr_d;
      sdr_q        <= sdr_d;
      udr_q        <= udr_d;
      rti_q        <= rti_d;
    end
  end

  assign host.cmd_ready  = cmd_ready_q;
  assign host.rsp_valid  = rsp_valid_q;
  assign host.rsp_dr     = rsp_dr_q;
  assign host.rsp_ir_out = rsp_ir_out_q;
  assign vji_tck         = tck_q;
  assign vji_tdi         = tdi_q;
  assign vji_ir_in       = ir_in_q;
  assign vji_uir         = uir_q;
  assign vji_cdr         = cdr_q;
  assign vji_sdr         = sdr_q;
  assign vji_udr         = udr_q;
  assign vji_rti         = rti_q;
endmodule

// File: tb/tb_nios_jtag_host_sequencer.sv
// Bench for nios_jtag_host_sequencer: two instances (TCK_DIV=2 and TCK_DIV=1), each driving
// a one-period-delay loopback target, checked against a transaction-level model.
module tb_nios_jtag_host_sequencer;
  localparam int DR_W = 38;
  localparam int IR_W = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  nios_jtag_host_sequencer_if #(.DR_W(DR_W), .IR_W(IR_W)) ha ();
  nios_jtag_host_sequencer_if #(.DR_W(DR_W), .IR_W(IR_W)) hb ();

  logic a_tck, a_tdi, a_uir, a_cdr, a_sdr, a_udr, a_rti;
  logic [IR_W-1:0] a_ir_in;
  logic [IR_W-1:0] a_ir_out = '0;
  logic a_tdo = 1'b0;
  logic a_cap = 1'b0;

  logic b_tck, b_tdi, b_uir, b_cdr, b_sdr, b_udr, b_rti;
  logic [IR_W-1:0] b_ir_in;
  logic [IR_W-1:0] b_ir_out = '0;
  logic b_tdo = 1'b0;
  logic b_cap = 1'b0;

  nios_jtag_host_sequencer #(.DR_W(DR_W), .IR_W(IR_W), .TCK_DIV(2), .RTI_CYC(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .host(ha),
    .vji_tck(a_tck), .vji_tdi(a_tdi), .vji_tdo(a_tdo),
    .vji_ir_in(a_ir_in), .vji_ir_out(a_ir_out),
    .vji_uir(a_uir), .vji_cdr(a_cdr), .vji_sdr(a_sdr), .vji_udr(a_udr), .vji_rti(a_rti)
  );

  nios_jtag_host_sequencer #(.DR_W(DR_W), .IR_W(IR_W), .TCK_DIV(1), .RTI_CYC(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .host(hb),
    .vji_tck(b_tck), .vji_tdi(b_tdi), .vji_tdo(b_tdo),
    .vji_ir_in(b_ir_in), .vji_ir_out(b_ir_out),
    .vji_uir(b_uir), .vji_cdr(b_cdr), .vji_sdr(b_sdr), .vji_udr(b_udr), .vji_rti(b_rti)
  );

  // Loopback targets: capture tdi on tck rise, present it on tdo from the next falling edge.
  always @(posedge a_tck) a_cap <= a_tdi;
  always @(negedge a_tck) a_tdo <= a_cap;
  always @(posedge b_tck) b_cap <= b_tdi;
  always @(negedge b_tck) b_tdo <= b_cap;

  int n_uir = 0, n_cdr = 0, n_sdr = 0, n_udr = 0, n_rti = 0, n_multi = 0;
  always @(posedge a_tck) begin
    n_uir = n_uir + (a_uir ? 1 : 0);
    n_cdr = n_cdr + (a_cdr ? 1 : 0);
    n_sdr = n_sdr + (a_sdr ? 1 : 0);
    n_udr = n_udr + (a_udr ? 1 : 0);
    n_rti = n_rti + (a_rti ? 1 : 0);
    if ((a_uir ? 1 : 0) + (a_cdr ? 1 : 0) + (a_sdr ? 1 : 0) + (a_udr ? 1 : 0) + (a_rti ? 1 : 0) != 1)
      n_multi = n_multi + 1;
  end

  int r_lat, r_unstable, r_uir, r_cdr, r_sdr, r_udr, r_rti, r_multi;
  logic [DR_W-1:0] r_dr;
  logic [IR_W-1:0] r_ir, r_ir_in;
  logic r_post_valid, r_post_ready, r_post2_ready, r_post2_uir;

  // Transaction-level reference: latency from period counts, response = previous-period tdi.
  logic [DR_W-1:0] m_prev_dr = '0;

  function automatic int exp_latency(input int tdiv, input bit skip, input int rti);
    return 1 + 2 * tdiv * (1 + (skip ? 0 : DR_W + 2) + rti);
  endfunction

  task automatic model_dr(input logic [DR_W-1:0] dr, input bit skip, output logic [DR_W-1:0] exp);
    if (!skip) m_prev_dr = dr << 1;
    exp = m_prev_dr;
  endtask

  function automatic logic [DR_W-1:0] rand_dr();
    logic [63:0] v;
    v = {$urandom, $urandom};
    return v[DR_W-1:0];
  endfunction

  task automatic drive_txn(input logic [IR_W-1:0] ir, input logic [DR_W-1:0] dr, input bit skip,
                           input logic [IR_W-1:0] irout, input int hold, input bit busy_valid);
    int w;
    int b_u, b_c, b_s, b_d, b_r, b_m;
    r_unstable    = 0;
    r_post2_ready = 1'bx;
    r_post2_uir   = 1'bx;
    a_ir_out = irout;
    @(negedge clk);
    ha.cmd_valid = 1'b1;
    ha.cmd_ir = ir;
    ha.cmd_dr = dr;
    ha.cmd_skip_dr = skip;
    ha.rsp_ready = 1'b0;
    w = 0;
    while (ha.cmd_ready !== 1'b1 && w < 400) begin
      @(negedge clk);
      w++;
    end
    b_u = n_uir; b_c = n_cdr; b_s = n_sdr; b_d = n_udr; b_r = n_rti; b_m = n_multi;
    @(negedge clk);
    ha.cmd_valid = busy_valid;
    ha.cmd_ir = IR_W'($urandom);
    ha.cmd_dr = rand_dr();
    ha.cmd_skip_dr = 1'($urandom);
    r_lat = 1;
    while (ha.rsp_valid !== 1'b1 && r_lat < 1000) begin
      @(negedge clk);
      r_lat++;
    end
    r_dr = ha.rsp_dr;
    r_ir = ha.rsp_ir_out;
    r_ir_in = a_ir_in;
    r_uir = n_uir - b_u; r_cdr = n_cdr - b_c; r_sdr = n_sdr - b_s;
    r_udr = n_udr - b_d; r_rti = n_rti - b_r; r_multi = n_multi - b_m;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (ha.rsp_valid !== 1'b1 || ha.rsp_dr !== r_dr || ha.rsp_ir_out !== r_ir || ha.cmd_ready !== 1'b0)
        r_unstable++;
    end
    ha.rsp_ready = 1'b1;
    @(negedge clk);
    ha.rsp_ready = 1'b0;
    r_post_valid = ha.rsp_valid;
    r_post_ready = ha.cmd_ready;
    if (busy_valid) begin
      @(negedge clk);
      r_post2_ready = ha.cmd_ready;
      r_post2_uir = a_uir;
    end
    ha.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({a_tck, a_tdi, a_uir, a_cdr, a_sdr, a_udr, a_rti, a_ir_in} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_vji got=%b want=0", {a_tck, a_tdi, a_uir, a_cdr, a_sdr, a_udr, a_rti, a_ir_in});
    end
    total++;
    if ({ha.cmd_ready, ha.rsp_valid, ha.rsp_dr, ha.rsp_ir_out} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_host got rdy=%b vld=%b dr=%h ir=%b want all 0",
               ha.cmd_ready, ha.rsp_valid, ha.rsp_dr, ha.rsp_ir_out);
    end
    reset_n = 1'b1;
    @(negedge clk);
    total++;
    if (ha.cmd_ready !== 1'b1 || hb.cmd_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_release_ready got a=%b b=%b want 1", ha.cmd_ready, hb.cmd_ready);
    end
  endtask

  task automatic test_loopback();
    logic [DR_W-1:0] dr, exp;
    dr = 38'h2A_5A5A_A5A5;
    drive_txn(2'b01, dr, 1'b0, 2'b01, 0, 1'b0);
    model_dr(dr, 1'b0, exp);
    total++;
    if (r_lat !== 169) begin bad++; $display("[TB] FAIL loop_latency got=%0d want=169", r_lat); end
    total++;
    if (r_dr !== exp) begin bad++; $display("[TB] FAIL loop_rsp_dr got=%h want=%h", r_dr, exp); end
    total++;
    if (r_ir !== 2'b01 || r_ir_in !== 2'b01) begin
      bad++;
      $display("[TB] FAIL loop_ir got ir_out=%b ir_in=%b want 01/01", r_ir, r_ir_in);
    end
    total++;
    if (r_uir != 1 || r_cdr != 1 || r_sdr != DR_W || r_udr != 1 || r_rti != 1 || r_multi != 0) begin
      bad++;
      $display("[TB] FAIL loop_strobes got u=%0d c=%0d s=%0d d=%0d r=%0d multi=%0d want 1/1/38/1/1/0",
               r_uir, r_cdr, r_sdr, r_udr, r_rti, r_multi);
    end
    total++;
    if (r_post_valid !== 1'b0 || r_post_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL loop_ack got vld=%b rdy=%b want 0/1", r_post_valid, r_post_ready);
    end
  endtask

  task automatic test_ir_only();
    logic [DR_W-1:0] exp;
    drive_txn(2'b10, rand_dr(), 1'b1, 2'b11, 0, 1'b0);
    model_dr('0, 1'b1, exp);
    total++;
    if (r_lat !== 9) begin bad++; $display("[TB] FAIL iro_latency got=%0d want=9", r_lat); end
    total++;
    if (r_ir !== 2'b11 || r_ir_in !== 2'b10) begin
      bad++;
      $display("[TB] FAIL iro_ir got ir_out=%b ir_in=%b want 11/10", r_ir, r_ir_in);
    end
    total++;
    if (r_dr !== exp) begin bad++; $display("[TB] FAIL iro_rsp_dr got=%h want=%h", r_dr, exp); end
    total++;
    if (r_uir != 1 || r_cdr != 0 || r_sdr != 0 || r_udr != 0 || r_rti != 1 || r_multi != 0) begin
      bad++;
      $display("[TB] FAIL iro_strobes got u=%0d c=%0d s=%0d d=%0d r=%0d multi=%0d want 1/0/0/0/1/0",
               r_uir, r_cdr, r_sdr, r_udr, r_rti, r_multi);
    end
  endtask

  task automatic test_random();
    logic [DR_W-1:0] dr, exp;
    logic [IR_W-1:0] ir, irout;
    bit skip;
    int hold;
    for (int n = 0; n < 10; n++) begin
      dr = rand_dr();
      ir = IR_W'($urandom);
      irout = IR_W'($urandom);
      skip = ($urandom_range(0, 3) == 0);
      hold = $urandom_range(0, 3);
      drive_txn(ir, dr, skip, irout, hold, 1'b0);
      model_dr(dr, skip, exp);
      total++;
      if (r_lat != exp_latency(2, skip, 1) || r_dr !== exp || r_ir !== irout || r_ir_in !== ir) begin
        bad++;
        $display("[TB] FAIL rand_rsp[%0d] got lat=%0d dr=%h ir=%b ir_in=%b want lat=%0d dr=%h ir=%b ir_in=%b",
                 n, r_lat, r_dr, r_ir, r_ir_in, exp_latency(2, skip, 1), exp, irout, ir);
      end
      total++;
      if (r_sdr != (skip ? 0 : DR_W) || r_multi != 0 || r_unstable != 0 ||
          r_post_valid !== 1'b0 || r_post_ready !== 1'b1) begin
        bad++;
        $display("[TB] FAIL rand_ctl[%0d] got sdr=%0d multi=%0d unstable=%0d vld=%b rdy=%b want %0d/0/0/0/1",
                 n, r_sdr, r_multi, r_unstable, r_post_valid, r_post_ready, skip ? 0 : DR_W);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DR_W-1:0] dr, exp;
    int w;
    dr = rand_dr();
    drive_txn(2'b11, dr, 1'b0, 2'b10, 20, 1'b1);
    model_dr(dr, 1'b0, exp);
    total++;
    if (r_unstable != 0 || r_dr !== exp) begin
      bad++;
      $display("[TB] FAIL bp_hold got unstable=%0d dr=%h want 0 dr=%h", r_unstable, r_dr, exp);
    end
    total++;
    if (r_post_valid !== 1'b0 || r_post_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL bp_ack got vld=%b rdy=%b want 0/1", r_post_valid, r_post_ready);
    end
    total++;
    if (r_post2_ready !== 1'b0 || r_post2_uir !== 1'b1) begin
      bad++;
      $display("[TB] FAIL bp_next_accept got rdy=%b uir=%b want 0/1", r_post2_ready, r_post2_uir);
    end
    w = 0;
    while (ha.rsp_valid !== 1'b1 && w < 1000) begin
      @(negedge clk);
      w++;
    end
    total++;
    if (ha.rsp_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_drain got vld=%b want 1", ha.rsp_valid); end
    ha.rsp_ready = 1'b1;
    @(negedge clk);
    ha.rsp_ready = 1'b0;
  endtask

  task automatic test_mid_shift_reset();
    logic [DR_W-1:0] dr, exp;
    int w, stray;
    a_ir_out = 2'b01;
    @(negedge clk);
    ha.cmd_valid = 1'b1;
    ha.cmd_ir = 2'b11;
    ha.cmd_dr = rand_dr();
    ha.cmd_skip_dr = 1'b0;
    ha.rsp_ready = 1'b1;
    w = 0;
    while (ha.cmd_ready !== 1'b1 && w < 400) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    ha.cmd_valid = 1'b0;
    repeat (49) @(negedge clk);
    total++;
    if (a_sdr !== 1'b1) begin bad++; $display("[TB] FAIL msr_in_sdr got sdr=%b want 1", a_sdr); end
    reset_n = 1'b0;
    @(negedge clk);
    total++;
    if ({a_tck, a_tdi, a_uir, a_cdr, a_sdr, a_udr, a_rti, a_ir_in} !== '0) begin
      bad++;
      $display("[TB] FAIL msr_vji got=%b want=0", {a_tck, a_tdi, a_uir, a_cdr, a_sdr, a_udr, a_rti, a_ir_in});
    end
    total++;
    if (ha.rsp_valid !== 1'b0 || ha.cmd_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL msr_host got vld=%b rdy=%b want 0/0", ha.rsp_valid, ha.cmd_ready);
    end
    reset_n = 1'b1;
    m_prev_dr = '0;
    stray = 0;
    repeat (200) begin
      @(negedge clk);
      if (ha.rsp_valid !== 1'b0) stray++;
    end
    ha.rsp_ready = 1'b0;
    total++;
    if (stray != 0) begin bad++; $display("[TB] FAIL msr_no_response got=%0d want=0", stray); end
    dr = rand_dr();
    drive_txn(2'b10, dr, 1'b0, 2'b11, 1, 1'b0);
    model_dr(dr, 1'b0, exp);
    total++;
    if (r_lat != 169 || r_dr !== exp || r_ir !== 2'b11) begin
      bad++;
      $display("[TB] FAIL msr_recover got lat=%0d dr=%h ir=%b want 169 dr=%h ir=11", r_lat, r_dr, r_ir, exp);
    end
  endtask

  task automatic test_tck_div1();
    logic [DR_W-1:0] dr, exp;
    logic prev_tck, prev_tdi;
    int w, lat, tog_err, tdi_err;
    dr = rand_dr();
    exp = dr << 1;
    b_ir_out = 2'b10;
    @(negedge clk);
    hb.cmd_valid = 1'b1;
    hb.cmd_ir = 2'b01;
    hb.cmd_dr = dr;
    hb.cmd_skip_dr = 1'b0;
    hb.rsp_ready = 1'b0;
    w = 0;
    while (hb.cmd_ready !== 1'b1 && w < 400) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    hb.cmd_valid = 1'b0;
    lat = 1;
    tog_err = (b_tck !== 1'b0) ? 1 : 0;
    tdi_err = 0;
    prev_tck = b_tck;
    prev_tdi = b_tdi;
    while (hb.rsp_valid !== 1'b1 && lat < 1000) begin
      @(negedge clk);
      lat++;
      if (hb.rsp_valid !== 1'b1) begin
        if (b_tck === prev_tck) tog_err++;
        if (b_tck === 1'b1 && b_tdi !== prev_tdi) tdi_err++;
        prev_tck = b_tck;
        prev_tdi = b_tdi;
      end
    end
    total++;
    if (lat != 85) begin bad++; $display("[TB] FAIL div1_latency got=%0d want=85", lat); end
    total++;
    if (tog_err != 0 || tdi_err != 0) begin
      bad++;
      $display("[TB] FAIL div1_tck_tdi got toggle_err=%0d tdi_err=%0d want 0/0", tog_err, tdi_err);
    end
    total++;
    if (hb.rsp_dr !== exp || hb.rsp_ir_out !== 2'b10 || b_tck !== 1'b0) begin
      bad++;
      $display("[TB] FAIL div1_rsp got dr=%h ir=%b tck=%b want dr=%h ir=10 tck=0",
               hb.rsp_dr, hb.rsp_ir_out, b_tck, exp);
    end
    hb.rsp_ready = 1'b1;
    @(negedge clk);
    hb.rsp_ready = 1'b0;
    total++;
    if (hb.rsp_valid !== 1'b0 || hb.cmd_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL div1_ack got vld=%b rdy=%b want 0/1", hb.rsp_valid, hb.cmd_ready);
    end
  endtask

  initial begin
    ha.cmd_valid = 1'b0; ha.cmd_ir = '0; ha.cmd_dr = '0; ha.cmd_skip_dr = 1'b0; ha.rsp_ready = 1'b0;
    hb.cmd_valid = 1'b0; hb.cmd_ir = '0; hb.cmd_dr = '0; hb.cmd_skip_dr = 1'b0; hb.rsp_ready = 1'b0;
    test_reset();
    test_loopback();
    test_ir_only();
    test_random();
    test_backpressure();
    test_mid_shift_reset();
    test_tck_div1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
